line_shift_buffer: RTL and testbench

- Parametrised multi-line shift buffer for the Bayer2RGB path. Supersedes the single fixed 8-bit line FIFO.
- Stores NUM_TAPS-1 previous lines in on-chip RAM.
- For every accepted pixel, presents a vertical column of NUM_TAPS pixels at the same column: the current pixel and the pixels 1..NUM_TAPS-1 lines above.
- Feeds the 3x3 / 5x5 demosaic window logic. Line length is runtime-configurable up to MAX_LINE_LEN.

---
 rtl/line_shift_buffer.sv | 182 ++++++++++++++++++
 tb/tb_line_shift_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/line_shift_buffer.sv
// line_shift_buffer
// Multi-line shift buffer for the Bayer2RGB path. For every accepted pixel it
// presents a vertical column of NUM_TAPS pixels at that column: the current
// pixel (tap 0) and the pixels 1..NUM_TAPS-1 lines above (taps 1..).
// NUM_TAPS-1 line RAMs are read and rewritten at the current column so that
// each RAM k always holds the line k rows above the one being received.
//
// Optional build macro: LINE_SHIFT_EDGE_REPLICATE_EN
//   When defined, output is also produced while the window is still filling,
//   and taps without a stored line repeat the oldest valid tap (top-edge
//   replication). When undefined, output is suppressed until NUM_TAPS-1
//   lines have been stored.
module line_shift_buffer #(
    parameter int DATA_W       = 8,
    parameter int MAX_LINE_LEN = 2048,
    parameter int NUM_TAPS     = 3,
    localparam int LEN_W       = $clog2(MAX_LINE_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LEN_W-1:0]           cfg_line_len,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    output logic [DATA_W*NUM_TAPS-1:0] out_taps,
    output logic [LEN_W-1:0]           out_col,
    output logic                       out_eol,
    output logic                       cfg_err
);

    localparam int ADDR_W = (MAX_LINE_LEN > 1) ? $clog2(MAX_LINE_LEN) : 1;
    localparam int LC_W   = $clog2(NUM_TAPS);

    localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_LINE_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE_C   = LEN_W'(1'b1);
    localparam logic [LEN_W-1:0] LEN_ZERO_C  = {LEN_W{1'b0}};
    localparam logic [LC_W-1:0]  LAST_LINE_C = LC_W'(NUM_TAPS - 1);
    localparam logic [LC_W-1:0]  LC_ONE_C    = LC_W'(1'b1);
    localparam logic [LC_W-1:0]  LC_ZERO_C   = {LC_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              state_r;
    logic [LEN_W-1:0]    col_r;
    logic [LC_W-1:0]     line_cnt_r;
    logic [LEN_W-1:0]    line_len_r;

    logic                restart_s;
    logic                cfg_bad_s;
    logic [LEN_W-1:0]    col_eff_s;
    logic [LC_W-1:0]     line_eff_s;
    logic [LEN_W-1:0]    len_eff_s;
    logic                last_col_s;
    logic [LEN_W-1:0]    col_next_s;
    logic [LC_W-1:0]     line_next_s;
    state_t              state_next_s;
    logic                emit_s;
    logic [ADDR_W-1:0]   addr_s;
`ifndef LINE_SHIFT_EDGE_REPLICATE_EN
    logic                run_s;
`endif

    // tap_s[0] is the incoming pixel, tap_s[k] the read data of line RAM k
    logic [DATA_W-1:0]          tap_s [NUM_TAPS];
    logic [DATA_W*NUM_TAPS-1:0] taps_s;

    assign tap_s[0] = in_data;

    // Effective position/length of the current pixel and next counter values
    always_comb begin
        restart_s = in_valid & (in_sof | (state_r == ST_IDLE));
        cfg_bad_s = (cfg_line_len == LEN_ZERO_C) | (cfg_line_len > MAX_LEN_C);

        if (restart_s) begin
            col_eff_s  = LEN_ZERO_C;
            line_eff_s = LC_ZERO_C;
            if (cfg_bad_s) begin
                len_eff_s = MAX_LEN_C;
            end else begin
                len_eff_s = cfg_line_len;
            end
        end else begin
            col_eff_s  = col_r;
            line_eff_s = line_cnt_r;
            len_eff_s  = line_len_r;
        end

        last_col_s = (col_eff_s == (len_eff_s - LEN_ONE_C));

        if (last_col_s) begin
            col_next_s = LEN_ZERO_C;
            if (line_eff_s == LAST_LINE_C) begin
                line_next_s = LAST_LINE_C;
            end else begin
                line_next_s = line_eff_s + LC_ONE_C;
            end
        end else begin
            col_next_s  = col_eff_s + LEN_ONE_C;
            line_next_s = line_eff_s;
        end

        if (line_next_s == LAST_LINE_C) begin
            state_next_s = ST_RUN;
        end else begin
            state_next_s = ST_FILL;
        end

`ifdef LINE_SHIFT_EDGE_REPLICATE_EN
        emit_s = in_valid;
`else
        run_s  = ~restart_s & (state_r == ST_RUN);
        emit_s = in_valid & run_s;
`endif

        addr_s = col_eff_s[ADDR_W-1:0];
    end

    // Line RAMs: read at the current column, then shift the column down one line
    for (genvar k = 1; k < NUM_TAPS; k++) begin : g_line_ram
        logic [DATA_W-1:0] mem_r [MAX_LINE_LEN];

        assign tap_s[k] = mem_r[addr_s];

        // Read-before-write: RAM k takes RAM k-1's old word at the same column
        always_ff @(posedge clk) begin
            if (in_valid && !rst) begin
                mem_r[addr_s] <= tap_s[k-1];
            end
        end
    end

    // Assemble the tap column, replicating the oldest valid line when enabled
    always_comb begin
        taps_s = {(DATA_W*NUM_TAPS){1'b0}};
        for (int k = 0; k < NUM_TAPS; k++) begin
`ifdef LINE_SHIFT_EDGE_REPLICATE_EN
            if (LC_W'(k) > line_eff_s) begin
                taps_s[k*DATA_W +: DATA_W] = tap_s[line_eff_s];
            end else begin
                taps_s[k*DATA_W +: DATA_W] = tap_s[k];
            end
`else
            taps_s[k*DATA_W +: DATA_W] = tap_s[k];
`endif
        end
    end

    // Control FSM, counters, length latch, sticky error and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            col_r      <= LEN_ZERO_C;
            line_cnt_r <= LC_ZERO_C;
            line_len_r <= MAX_LEN_C;
            cfg_err    <= 1'b0;
            out_valid  <= 1'b0;
            out_taps   <= {(DATA_W*NUM_TAPS){1'b0}};
            out_col    <= LEN_ZERO_C;
            out_eol    <= 1'b0;
        end else begin
            if (in_valid) begin
                state_r    <= state_next_s;
                col_r      <= col_next_s;
                line_cnt_r <= line_next_s;
                line_len_r <= len_eff_s;
            end
            cfg_err   <= cfg_err | (restart_s & cfg_bad_s);
            out_valid <= emit_s;
            out_eol   <= emit_s & last_col_s;
            if (emit_s) begin
                out_taps <= taps_s;
                out_col  <= col_eff_s;
            end
        end
    end

endmodule

// File: tb/tb_line_shift_buffer.sv
// Self-checking bench for line_shift_buffer (DATA_W=8, NUM_TAPS=3).
// Reference model: every pixel of the current frame is kept in a queue; the
// pixel at frame index p sits at column p % len, line p / len, and tap k is
// simply the frame pixel at index p - k*len.
module tb_line_shift_buffer;

    localparam int DATA_W       = 8;
    localparam int MAX_LINE_LEN = 2048;
    localparam int NUM_TAPS     = 3;
    localparam int LEN_W        = $clog2(MAX_LINE_LEN + 1);

    logic                       clk = 1'b0;
    logic                       rst;
    logic [LEN_W-1:0]           cfg_line_len;
    logic                       in_valid;
    logic                       in_sof;
    logic [DATA_W-1:0]          in_data;
    logic                       out_valid;
    logic [DATA_W*NUM_TAPS-1:0] out_taps;
    logic [LEN_W-1:0]           out_col;
    logic                       out_eol;
    logic                       cfg_err;

    always #5 clk = ~clk;

    line_shift_buffer #(
        .DATA_W       (DATA_W),
        .MAX_LINE_LEN (MAX_LINE_LEN),
        .NUM_TAPS     (NUM_TAPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_line_len (cfg_line_len),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_taps     (out_taps),
        .out_col      (out_col),
        .out_eol      (out_eol),
        .cfg_err      (cfg_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit                     in_frame_m;
    int                     len_m;
    bit                     cfg_err_m;
    logic [DATA_W-1:0]      frame_q [$];
    bit                     exp_valid;
    logic [DATA_W*NUM_TAPS-1:0] exp_taps;
    int                     exp_col;
    bit                     exp_eol;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_pixel(input bit sof, input logic [LEN_W-1:0] cfg, input logic [DATA_W-1:0] d);
        int p;
        int line;
        int col;
        int depth;
        if (sof || !in_frame_m) begin
            frame_q.delete();
            in_frame_m = 1'b1;
            if (cfg == 0 || cfg > MAX_LINE_LEN) begin
                len_m     = MAX_LINE_LEN;
                cfg_err_m = 1'b1;
            end else begin
                len_m = int'(cfg);
            end
        end
        frame_q.push_back(d);
        p    = frame_q.size() - 1;
        line = p / len_m;
        col  = p % len_m;
`ifdef LINE_SHIFT_EDGE_REPLICATE_EN
        exp_valid = 1'b1;
`else
        exp_valid = (line >= NUM_TAPS - 1);
`endif
        exp_taps = '0;
        if (exp_valid) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                depth = (k < line) ? k : line;
                exp_taps[k*DATA_W +: DATA_W] = frame_q[p - depth * len_m];
            end
        end
        exp_col = col;
        exp_eol = exp_valid && (col == len_m - 1);
    endtask

    // one clock: drive inputs, update model at the edge, compare 1 time unit later
    task automatic cycle(input bit v, input bit sof, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        if (v) begin
            model_pixel(sof, cfg_line_len, d);
        end else begin
            exp_valid = 1'b0;
            exp_eol   = 1'b0;
        end
        #1;
        check_eq("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            check_eq("out_taps", out_taps, exp_taps);
            check_eq("out_col", out_col, exp_col);
        end
        check_eq("out_eol", out_eol, exp_eol);
        check_eq("cfg_err", cfg_err, cfg_err_m);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_frame_m = 1'b0;
        cfg_err_m  = 1'b0;
        exp_valid  = 1'b0;
        exp_eol    = 1'b0;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_taps", out_taps, 24'h000000);
        check_eq("rst_out_col", out_col, 12'd0);
        check_eq("rst_out_eol", out_eol, 1'b0);
        check_eq("rst_cfg_err", cfg_err, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_sof       = 1'b0;
        in_data      = 8'h00;
        cfg_line_len = 12'd4;
        in_frame_m   = 1'b0;
        cfg_err_m    = 1'b0;

        // reset, then 3 lines of 0x00..0x0B with sof on the first pixel
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, i == 0, 8'(i));
            if (i == 8) begin
                check_eq("tp_taps_px08", out_taps, 24'h000408);
                check_eq("tp_col_px08", out_col, 12'd0);
            end
            if (i == 11) begin
                check_eq("tp_eol_px0b", out_eol, 1'b1);
            end
        end

        // same stream with in_valid toggling every other cycle
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, i == 0, 8'(i));
            cycle(1'b0, 1'b0, 8'($urandom_range(255)));
        end

        // mid-frame sof after 2.5 lines, then 3 more lines
        for (int i = 0; i < 10; i++) cycle(1'b1, i == 0, 8'($urandom_range(255)));
        for (int i = 0; i < 12; i++) cycle(1'b1, i == 0, 8'($urandom_range(255)));

        // illegal length 0: wrap at MAX_LINE_LEN, sticky error
        cfg_line_len = 12'd0;
        for (int i = 0; i < MAX_LINE_LEN + 2; i++) cycle(1'b1, i == 0, 8'($urandom_range(255)));
        cfg_line_len = 12'd4;
        for (int i = 0; i < 6; i++) cycle(1'b1, i == 0, 8'($urandom_range(255)));
        check_eq("cfg_err_sticky", cfg_err, 1'b1);
        do_reset();

        // illegal length above MAX_LINE_LEN
        cfg_line_len = 12'd3000;
        for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, 8'($urandom_range(255)));
        do_reset();

        // reset at column 2 of line 3, then a stream without sof from IDLE
        cfg_line_len = 12'd4;
        for (int i = 0; i < 10; i++) cycle(1'b1, i == 0, 8'($urandom_range(255)));
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'($urandom_range(255)));

        // randomized traffic: gaps, sof, line lengths 1..6, ignored mid-frame cfg changes
        for (int i = 0; i < 800; i++) begin
            bit v;
            bit s;
            v = ($urandom_range(3) != 0);
            s = v && ($urandom_range(39) == 0);
            if ($urandom_range(7) == 0) cfg_line_len = 12'($urandom_range(6, 1));
            cycle(v, s, 8'($urandom_range(255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
